// File: rtl/sync_rom_seq_pkg.sv
// Shared constants for sync_rom_seq.
//   MODE_* : content pattern selectors for rom_pattern.
//   state_t: playback FSM state encoding.
package sync_rom_seq_pkg;

  localparam int MODE_ONEHOT    = 0;
  localparam int MODE_THERMO    = 1;
  localparam int MODE_REVONEHOT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_rom_seq_if.sv
// Bus bundle for sync_rom_seq.
//   Requests (master -> slave): rd_en, address, start, last_addr, loop_en, stop.
//   Responses (slave -> master): data_out, valid, busy, done.
interface sync_rom_seq_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] address;
  logic              start;
  logic [ADDR_W-1:0] last_addr;
  logic              loop_en;
  logic              stop;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              busy;
  logic              done;

  modport master (
    output rd_en, address, start, last_addr, loop_en, stop,
    input  data_out, valid, busy, done
  );

  modport slave (
    input  rd_en, address, start, last_addr, loop_en, stop,
    output data_out, valid, busy, done
  );
endinterface

// File: rtl/sync_rom_seq_rom_pattern.sv
// rom_pattern: combinational ROM content generator.
//   index : word address
//   word  : pattern word, k = index mod DATA_W
//           MODE_ONEHOT only bit k, MODE_THERMO bits 0..k,
//           MODE_REVONEHOT only bit DATA_W-1-k.
module rom_pattern
  import sync_rom_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int MODE   = MODE_ONEHOT
) (
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned DW = DATA_W;

  int unsigned k;
  int unsigned rk;

  always_comb begin
    k    = 32'(index) % DW;
    rk   = DW - 1 - k;
    word = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      case (MODE)
        MODE_ONEHOT:    word[i] = (i == k);
        MODE_THERMO:    word[i] = (i <= k);
        MODE_REVONEHOT: word[i] = (i == rk);
        default:        word[i] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/sync_rom_seq.sv
// sync_rom_seq: pattern ROM with direct reads and sequenced playback.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : rd_en/address direct read (IDLE only),
//                  start/last_addr/loop_en playback from address 0,
//                  stop abort (RUN only); data_out registered word,
//                  valid one-cycle qualifier, busy in RUN, done final word.
module sync_rom_seq
  import sync_rom_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int MODE   = MODE_ONEHOT
) (
  input  logic          clock,
  input  logic          reset,
  sync_rom_seq_if.slave bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] rom_idx;
  logic [DATA_W-1:0] rom_word;

  // Single ROM shared by both paths: the counter owns it in RUN,
  // the direct-read address owns it in IDLE.
  assign rom_idx = (state_q == ST_RUN) ? cnt_q : bus.address;

  rom_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MODE   (MODE)
  ) u_rom (
    .index (rom_idx),
    .word  (rom_word)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.stop)                           state_d = ST_IDLE;
        else if (cnt_q == last_q && !bus.loop_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_d = bus.last_addr;
          cnt_d  = '0;
        end else if (bus.rd_en) begin
          data_d  = rom_word;
          valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.stop) begin
          data_d  = rom_word;
          valid_d = 1'b1;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == last_q) begin
            if (bus.loop_en) cnt_d  = '0;
            else             done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == ST_RUN);

endmodule
